fetch_stall_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_stall_ctrl_if.sv | 36 +++
 rtl/pipe_reg_en_clr.sv | 29 ++
 rtl/fetch_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/stall front end.
//   NOP_INSTR        : instruction word used for bubbles and flushes
//   DEFAULT_RESET_PC : default PC loaded on reset
//   id_ex_ctrl_t     : decoded control bundle carried from ID into EX
//   DEFAULT_CTRL_W   : width of id_ex_ctrl_t
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_op;
    } id_ex_ctrl_t;

    localparam int unsigned DEFAULT_CTRL_W = $bits(id_ex_ctrl_t);

endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// Hazard/fetch bus between the front-end sequencer and its environment.
//   master : drives hold/stall/branch requests, imem data and ID control
//   slave  : the sequencer; returns PC, IF/ID, ID/EX control and stall count
interface fetch_stall_ctrl_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = DEFAULT_CTRL_W,
    parameter int unsigned CNT_W  = 16
);
    logic              ext_hold;
    logic              hz_stall;
    logic              br_taken;
    logic [XLEN-1:0]   br_target;
    logic [XLEN-1:0]   imem_instr;
    logic [CTRL_W-1:0] id_ctrl;

    logic [XLEN-1:0]   pc_o;
    logic [XLEN-1:0]   if_id_pc;
    logic [XLEN-1:0]   if_id_instr;
    logic              if_id_valid;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic              id_ex_valid;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output ext_hold, hz_stall, br_taken, br_target, imem_instr, id_ctrl,
        input  pc_o, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_valid, stall_cnt
    );

    modport slave (
        input  ext_hold, hz_stall, br_taken, br_target, imem_instr, id_ctrl,
        output pc_o, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_valid, stall_cnt
    );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// Pipeline register with hold enable and synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (loads RST_VAL)
//   en         : load d when high, hold when low
//   clr        : load CLR_VAL; takes priority over en
//   d, q       : data in / registered data out
module pipe_reg_en_clr #(
    parameter int unsigned  W       = 1,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Front-end sequencer: owns PC, IF/ID and the control half of ID/EX, and
// applies ext_hold > hz_stall > br_taken > advance each cycle. Counts
// load-use stall cycles in a saturating counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_stall_ctrl_if.slave (hazard inputs, imem data,
//                ID control in; PC, IF/ID, ID/EX control, stall_cnt out)
// Build option: BRANCH_DELAY_SLOT_EN keeps the fetched instruction in IF/ID
// on a taken branch (delay slot); otherwise it is flushed.
module fetch_stall_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned     CTRL_W   = DEFAULT_CTRL_W,
    parameter int unsigned     CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    fetch_stall_ctrl_if.slave bus
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    localparam int unsigned       IFID_W      = 2 * XLEN + 1;
    localparam int unsigned       IDEX_W      = CTRL_W + 1;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {{XLEN{1'b0}}, XLEN'(NOP_INSTR), 1'b0};
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_next;
    logic [IFID_W-1:0] if_id_q;
    logic [IDEX_W-1:0] id_ex_q;
    logic              if_id_valid_q;
    logic              front_en;
    logic              if_id_clr;
    logic              id_ex_en;
    logic              id_ex_clr;
    logic              cnt_inc;
    logic [CNT_W-1:0]  stall_cnt_q;

    assign if_id_valid_q = if_id_q[0];

    // Priority decode of hold / stall / redirect / advance
    always_comb begin
        front_en  = 1'b0;
        if_id_clr = 1'b0;
        id_ex_en  = 1'b0;
        id_ex_clr = 1'b0;
        cnt_inc   = 1'b0;
        pc_next   = pc_q + XLEN'(4);
        if (!bus.ext_hold) begin
            id_ex_en = 1'b1;
            if (bus.hz_stall) begin
                // Branch is ignored: its operands are not ready yet
                id_ex_clr = 1'b1;
                cnt_inc   = 1'b1;
            end else begin
                front_en = 1'b1;
                if (bus.br_taken) begin
                    pc_next   = bus.br_target & ~XLEN'(3);
                    if_id_clr = !DELAY_SLOT;
                end else begin
                    id_ex_clr = !if_id_valid_q;
                end
            end
        end
    end

    // Fetch PC
    pipe_reg_en_clr #(
        .W       (XLEN),
        .RST_VAL (RESET_PC),
        .CLR_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (front_en),
        .clr   (1'b0),
        .d     (pc_next),
        .q     (pc_q)
    );

    // IF/ID: {pc, instr, valid}
    pipe_reg_en_clr #(
        .W       (IFID_W),
        .RST_VAL (IFID_BUBBLE),
        .CLR_VAL (IFID_BUBBLE)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (front_en),
        .clr   (if_id_clr),
        .d     ({pc_q, bus.imem_instr, 1'b1}),
        .q     (if_id_q)
    );

    // ID/EX control: {ctrl, valid}; valid follows the ID slot
    pipe_reg_en_clr #(
        .W       (IDEX_W),
        .RST_VAL (IDEX_W'(0)),
        .CLR_VAL (IDEX_W'(0))
    ) u_id_ex_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (id_ex_en),
        .clr   (id_ex_clr),
        .d     ({bus.id_ctrl, if_id_valid_q}),
        .q     (id_ex_q)
    );

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (cnt_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_o        = pc_q;
    assign bus.if_id_pc    = if_id_q[IFID_W-1 -: XLEN];
    assign bus.if_id_instr = if_id_q[XLEN:1];
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.id_ex_ctrl  = id_ex_q[IDEX_W-1:1];
    assign bus.id_ex_valid = id_ex_q[0];
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Bench for fetch_stall_ctrl: two instances (default parameters, and
// CNT_W=4 with RESET_PC=32'hFFFF_FFFC) share one stimulus stream and are
// checked against a reference model of the pipeline rules.
module tb_fetch_stall_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ext_hold;
    logic       hz_stall;
    logic       br_taken;
    logic [31:0] br_target;
    logic [8:0] id_ctrl;

    int checks;
    int errors;

    fetch_stall_ctrl_if #(.XLEN(32), .CTRL_W(9), .CNT_W(16)) bus0 ();
    fetch_stall_ctrl_if #(.XLEN(32), .CTRL_W(9), .CNT_W(4))  bus1 ();

    fetch_stall_ctrl #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .CTRL_W(9), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    fetch_stall_ctrl #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFFC), .CTRL_W(9), .CNT_W(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a function of address
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus0.ext_hold   = ext_hold;
    assign bus0.hz_stall   = hz_stall;
    assign bus0.br_taken   = br_taken;
    assign bus0.br_target  = br_target;
    assign bus0.id_ctrl    = id_ctrl;
    assign bus0.imem_instr = imem(bus0.pc_o);
    assign bus1.ext_hold   = ext_hold;
    assign bus1.hz_stall   = hz_stall;
    assign bus1.br_taken   = br_taken;
    assign bus1.br_target  = br_target;
    assign bus1.id_ctrl    = id_ctrl;
    assign bus1.imem_instr = imem(bus1.pc_o);

    // Observed outputs, indexed by instance
    logic [31:0] o_pc[2], o_ifpc[2], o_ifi[2], o_cnt[2];
    logic        o_ifv[2], o_exv[2];
    logic [8:0]  o_ctrl[2];

    assign o_pc[0]   = bus0.pc_o;        assign o_pc[1]   = bus1.pc_o;
    assign o_ifpc[0] = bus0.if_id_pc;    assign o_ifpc[1] = bus1.if_id_pc;
    assign o_ifi[0]  = bus0.if_id_instr; assign o_ifi[1]  = bus1.if_id_instr;
    assign o_ifv[0]  = bus0.if_id_valid; assign o_ifv[1]  = bus1.if_id_valid;
    assign o_ctrl[0] = bus0.id_ex_ctrl;  assign o_ctrl[1] = bus1.id_ex_ctrl;
    assign o_exv[0]  = bus0.id_ex_valid; assign o_exv[1]  = bus1.id_ex_valid;
    assign o_cnt[0]  = 32'(bus0.stall_cnt);
    assign o_cnt[1]  = 32'(bus1.stall_cnt);

    // Reference model state
    logic [31:0] m_pc[2], m_ifpc[2], m_ifi[2];
    logic        m_ifv[2], m_exv[2];
    logic [8:0]  m_ctrl[2];
    int unsigned m_cnt[2];
    int unsigned m_max[2];
    logic [31:0] m_rp[2];

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = m_rp[i]; m_ifpc[i] = '0; m_ifi[i] = '0; m_ifv[i] = 1'b0;
            m_ctrl[i] = '0; m_exv[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    // One clock of the pipeline rules applied to the current inputs
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] fpc;
            fpc = m_pc[i];
            if (ext_hold) begin
                // everything holds
            end else if (hz_stall) begin
                m_ctrl[i] = '0;
                m_exv[i]  = 1'b0;
                if (m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
            end else if (br_taken) begin
                m_ctrl[i] = id_ctrl;
                m_exv[i]  = m_ifv[i];
                m_pc[i]   = br_target - (br_target % 4);
                if (DS) begin
                    m_ifpc[i] = fpc; m_ifi[i] = imem(fpc); m_ifv[i] = 1'b1;
                end else begin
                    m_ifpc[i] = '0; m_ifi[i] = '0; m_ifv[i] = 1'b0;
                end
            end else begin
                m_ctrl[i] = m_ifv[i] ? id_ctrl : 9'd0;
                m_exv[i]  = m_ifv[i];
                m_pc[i]   = 32'((64'(fpc) + 64'd4) % 64'h1_0000_0000);
                m_ifpc[i] = fpc; m_ifi[i] = imem(fpc); m_ifv[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle();
        ext_hold = 1'b0; hz_stall = 1'b0; br_taken = 1'b0;
        br_target = $urandom; id_ctrl = 9'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_pc[i] !== m_rp[i] || o_ifv[i] !== 1'b0 || o_exv[i] !== 1'b0 ||
                    o_ifi[i] !== 32'h0 || o_ifpc[i] !== 32'h0 || o_ctrl[i] !== 9'h0 ||
                    o_cnt[i] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset dut%0d: pc=%h ifv=%b exv=%b ifi=%h cnt=%0d, required pc=%h and zeros",
                             i, o_pc[i], o_ifv[i], o_exv[i], o_ifi[i], o_cnt[i], m_rp[i]);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        logic [31:0] exp_pc[3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        for (int c = 0; c < 3; c++) begin
            id_ctrl = 9'($urandom);
            tick();
            checks++;
            if (o_pc[0] !== exp_pc[c]) begin
                errors++;
                $display("FAIL run_pc cycle%0d: got %h, required %h", c, o_pc[0], exp_pc[c]);
            end
            checks++;
            if (o_ifv[0] !== 1'b1 || o_ifpc[0] !== exp_pc[c] - 32'd4 || o_ifi[0] !== imem(exp_pc[c] - 32'd4)) begin
                errors++;
                $display("FAIL run_ifid cycle%0d: v=%b pc=%h instr=%h", c, o_ifv[0], o_ifpc[0], o_ifi[0]);
            end
            checks++;
            if (o_exv[0] !== (c != 0) || o_ctrl[0] !== ((c != 0) ? id_ctrl : 9'd0)) begin
                errors++;
                $display("FAIL run_idex cycle%0d: v=%b ctrl=%h, required v=%b", c, o_exv[0], o_ctrl[0], c != 0);
            end
            if (c == 0) begin
                checks++;
                if (o_pc[1] !== 32'h0) begin
                    errors++;
                    $display("FAIL pc_wrap: got %h, required 00000000", o_pc[1]);
                end
            end
        end
        checks++;
        if (o_cnt[0] !== 32'd0) begin
            errors++;
            $display("FAIL run_cnt: got %0d, required 0", o_cnt[0]);
        end
        // Return to pc_o = 8 for the load-use scenario
        br_taken = 1'b1; br_target = 32'h8;
        tick();
        idle();
        if (!DS) tick();
    endtask

    task automatic test_load_use();
        logic [31:0] pc_b, ifi_b;
        if (DS) tick();
        pc_b = m_pc[0]; ifi_b = m_ifi[0];
        hz_stall = 1'b1;
        tick();
        hz_stall = 1'b0;
        checks++;
        if (o_pc[0] !== pc_b || o_ifi[0] !== ifi_b) begin
            errors++;
            $display("FAIL load_use_hold: pc=%h instr=%h, required pc=%h instr=%h", o_pc[0], o_ifi[0], pc_b, ifi_b);
        end
        checks++;
        if (o_exv[0] !== 1'b0 || o_ctrl[0] !== 9'd0) begin
            errors++;
            $display("FAIL load_use_bubble: v=%b ctrl=%h, required 0/000", o_exv[0], o_ctrl[0]);
        end
        checks++;
        if (o_cnt[0] !== m_cnt[0]) begin
            errors++;
            $display("FAIL load_use_cnt: got %0d, required %0d", o_cnt[0], m_cnt[0]);
        end
        tick();
        checks++;
        if (o_pc[0] !== pc_b + 32'd4 || o_exv[0] !== 1'b1) begin
            errors++;
            $display("FAIL load_use_resume: pc=%h v=%b, required pc=%h v=1", o_pc[0], o_exv[0], pc_b + 32'd4);
        end
    endtask

    task automatic test_stall_vs_branch();
        logic [31:0] pc_b;
        pc_b = m_pc[0];
        hz_stall = 1'b1; br_taken = 1'b1; br_target = 32'h100;
        tick();
        checks++;
        if (o_pc[0] !== pc_b || o_exv[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_vs_branch: pc=%h v=%b, required pc=%h v=0", o_pc[0], o_exv[0], pc_b);
        end
        hz_stall = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_pc[i] !== 32'h100 || o_ifv[i] !== m_ifv[i]) begin
                errors++;
                $display("FAIL branch_after_stall dut%0d: pc=%h ifv=%b, required 00000100 %b", i, o_pc[i], o_ifv[i], m_ifv[i]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_taken_branch();
        logic exp_exv;
        exp_exv = m_ifv[0];
        br_taken = 1'b1; br_target = 32'h203;
        tick();
        checks++;
        if (o_pc[0] !== 32'h200) begin
            errors++;
            $display("FAIL branch_pc: got %h, required 00000200", o_pc[0]);
        end
        checks++;
        if (o_ifv[0] !== DS || o_exv[0] !== exp_exv) begin
            errors++;
            $display("FAIL branch_ifid: ifv=%b exv=%b, required ifv=%b exv=%b", o_ifv[0], o_exv[0], DS, exp_exv);
        end
        idle();
        tick();
        checks++;
        if (o_ifv[0] !== 1'b1 || o_ifpc[0] !== 32'h200 || o_pc[0] !== 32'h204) begin
            errors++;
            $display("FAIL branch_target_fetch: ifv=%b ifpc=%h pc=%h", o_ifv[0], o_ifpc[0], o_pc[0]);
        end
    endtask

    task automatic test_ext_hold();
        logic [31:0] s_pc, s_ifi, s_ifpc;
        logic        s_ifv, s_exv;
        logic [8:0]  s_ctrl;
        int unsigned s_cnt;
        s_pc = m_pc[0]; s_ifi = m_ifi[0]; s_ifpc = m_ifpc[0];
        s_ifv = m_ifv[0]; s_exv = m_exv[0]; s_ctrl = m_ctrl[0]; s_cnt = m_cnt[0];
        ext_hold = 1'b1; hz_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            br_taken = 1'($urandom); br_target = $urandom; id_ctrl = 9'($urandom);
            tick();
            checks++;
            if (o_pc[0] !== s_pc || o_ifi[0] !== s_ifi || o_ifpc[0] !== s_ifpc || o_ifv[0] !== s_ifv ||
                o_exv[0] !== s_exv || o_ctrl[0] !== s_ctrl || o_cnt[0] !== s_cnt) begin
                errors++;
                $display("FAIL ext_hold_freeze cycle%0d: pc=%h cnt=%0d exv=%b, required pc=%h cnt=%0d exv=%b",
                         c, o_pc[0], o_cnt[0], o_exv[0], s_pc, s_cnt, s_exv);
            end
        end
        ext_hold = 1'b0; br_taken = 1'b0;
        tick();
        checks++;
        if (o_pc[0] !== s_pc || o_exv[0] !== 1'b0 || o_cnt[0] !== s_cnt + 1) begin
            errors++;
            $display("FAIL ext_hold_release: pc=%h exv=%b cnt=%0d, required pc=%h exv=0 cnt=%0d",
                     o_pc[0], o_exv[0], o_cnt[0], s_pc, s_cnt + 1);
        end
        idle();
    endtask

    task automatic test_saturation();
        int unsigned c0;
        c0 = m_cnt[0];
        hz_stall = 1'b1;
        repeat (20) tick();
        hz_stall = 1'b0;
        checks++;
        if (o_cnt[1] !== 32'd15) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d, required 15", o_cnt[1]);
        end
        checks++;
        if (o_cnt[0] !== c0 + 20) begin
            errors++;
            $display("FAIL cnt_n_stalls: got %0d, required %0d", o_cnt[0], c0 + 20);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ext_hold  = ($urandom_range(0, 9) == 0);
            hz_stall  = ($urandom_range(0, 4) == 0);
            br_taken  = ($urandom_range(0, 6) == 0);
            br_target = $urandom;
            id_ctrl   = 9'($urandom);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_pc[i] !== m_pc[i] || o_ifpc[i] !== m_ifpc[i] || o_ifi[i] !== m_ifi[i] ||
                    o_ifv[i] !== m_ifv[i] || o_ctrl[i] !== m_ctrl[i] || o_exv[i] !== m_exv[i] ||
                    o_cnt[i] !== m_cnt[i]) begin
                    errors++;
                    $display("FAIL random c%0d dut%0d: pc=%h/%h ifpc=%h/%h ifi=%h/%h ifv=%b/%b ctrl=%h/%h exv=%b/%b cnt=%0d/%0d (got/required)",
                             c, i, o_pc[i], m_pc[i], o_ifpc[i], m_ifpc[i], o_ifi[i], m_ifi[i],
                             o_ifv[i], m_ifv[i], o_ctrl[i], m_ctrl[i], o_exv[i], m_exv[i], o_cnt[i], m_cnt[i]);
                end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        hz_stall = 1'b1;
        tick();
        hz_stall = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_pc[i] !== m_rp[i] || o_ifv[i] !== 1'b0 || o_exv[i] !== 1'b0 ||
                o_ctrl[i] !== 9'h0 || o_cnt[i] !== 32'h0 || o_ifi[i] !== 32'h0) begin
                errors++;
                $display("FAIL async_reset dut%0d: pc=%h ifv=%b exv=%b cnt=%0d, required pc=%h and zeros",
                         i, o_pc[i], o_ifv[i], o_exv[i], o_cnt[i], m_rp[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (o_pc[0] !== 32'h4 || o_ifpc[0] !== 32'h0 || o_ifv[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_fetch: pc=%h ifpc=%h ifv=%b, required 00000004 00000000 1",
                     o_pc[0], o_ifpc[0], o_ifv[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_rp[0] = 32'h0000_0000; m_max[0] = 65535;
        m_rp[1] = 32'hFFFF_FFFC; m_max[1] = 15;
        test_reset();
        test_run();
        test_load_use();
        test_stall_vs_branch();
        test_taken_branch();
        test_ext_hold();
        test_saturation();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
